// File: rtl/jtframe_ps2_pkg.sv
// Shared PS/2 keyboard protocol constants, controller state encoding and the
// command-queue helper used by the command sequencer.
package jtframe_ps2_pkg;

  localparam logic [7:0] BYTE_RESET    = 8'hFF;
  localparam logic [7:0] BYTE_SET_LED  = 8'hED;
  localparam logic [7:0] BYTE_ACK      = 8'hFA;
  localparam logic [7:0] BYTE_RESEND   = 8'hFE;
  localparam logic [7:0] BYTE_BAT_OK   = 8'hAA;
  localparam logic [7:0] BYTE_BAT_FAIL = 8'hFC;

  typedef enum logic [2:0] {
    ST_SEND,
    ST_WAIT_DONE,
    ST_WAIT_ACK,
    ST_WAIT_BAT,
    ST_IDLE,
    ST_FAULT
  } state_t;

  typedef enum logic [1:0] {
    Q_RST,
    Q_LED_CMD,
    Q_LED_ARG
  } cmd_t;

  function automatic logic [7:0] queue_byte(cmd_t cmd, logic [2:0] led_arg);
    case (cmd)
      Q_RST:     return BYTE_RESET;
      Q_LED_CMD: return BYTE_SET_LED;
      default:   return {5'd0, led_arg};
    endcase
  endfunction

endpackage

// File: rtl/jtframe_ps2_cmd_if.sv
// Byte-level link between the command sequencer (master) and the PS/2
// receiver/transmitter plus scan-code consumer (slave).
interface jtframe_ps2_cmd_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_req;
  logic       tx_done;
  logic [7:0] key_data;
  logic       key_valid;

  modport master (
    input  rx_data, rx_valid, tx_done,
    output tx_data, tx_req, key_data, key_valid
  );

  modport slave (
    output rx_data, rx_valid, tx_done,
    input  tx_data, tx_req, key_data, key_valid
  );
endinterface

// File: rtl/jtframe_ps2_timeout.sv
// Response watchdog: one cycle counter shared by all WAIT states plus the
// per-byte retry count.
module jtframe_ps2_timeout #(
  parameter logic [23:0] TIMEOUT   = 24'd1_000_000,
  parameter int          MAX_RETRY = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  input  logic bump,
  input  logic ack,
  output logic expire,
  output logic exhausted
);

  logic [23:0] cnt;
  logic [7:0]  retries;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples values from before the edge regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst || clear) cnt <= '0;
    else if (run)     cnt <= cnt + 24'd1;

    if (rst || ack)   retries <= '0;
    else if (bump)    retries <= retries + 8'd1;
  end

  assign expire    = run && (cnt == TIMEOUT - 24'd1);
  assign exhausted = retries >= 8'(MAX_RETRY);

endmodule

// File: rtl/jtframe_ps2_cmd.sv
// PS/2 keyboard command sequencer: reset/BAT handshake, ack/resend/timeout
// retries and scan-code forwarding. Define JTFRAME_PS2_LED_EN for LED sync.
module jtframe_ps2_cmd
  import jtframe_ps2_pkg::*;
#(
  parameter logic [23:0] TIMEOUT   = 24'd1_000_000,
  parameter int          MAX_RETRY = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  jtframe_ps2_cmd_if.master        bus,
  input  logic [2:0]               led,
  input  logic                     init,
  output logic                     ready,
  output logic                     fault
);

  state_t     state, state_n;
  cmd_t       cmd, cmd_n;
  logic       send, forward, bump, ack, latch_led, resend_req, retry_due;
  logic       ack_phase, expire, exhausted, timer_clear, timer_run;
  logic       led_pending;
  logic [2:0] led_arg;

  // NOTE: every signal written here gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_n    = state;
    cmd_n      = cmd;
    send       = 1'b0;
    forward    = 1'b0;
    bump       = 1'b0;
    ack        = 1'b0;
    latch_led  = 1'b0;
    resend_req = 1'b0;
    // tx_done and the response byte can land together; treat that as WAIT_ACK
    ack_phase  = (state == ST_WAIT_ACK) || (state == ST_WAIT_DONE && bus.tx_done);

    case (state)
      ST_SEND:      begin send = 1'b1; state_n = ST_WAIT_DONE; end
      ST_WAIT_DONE: if (bus.tx_done) state_n = ST_WAIT_ACK;
      ST_IDLE:      if (led_pending) begin
                      latch_led = 1'b1;
                      cmd_n     = Q_LED_CMD;
                      state_n   = ST_SEND;
                    end
      default: ;
    endcase

    if (bus.rx_valid) begin
      if (ack_phase && bus.rx_data == BYTE_ACK) begin
        ack = 1'b1;
        case (cmd)
          Q_RST:     state_n = ST_WAIT_BAT;
          Q_LED_CMD: begin cmd_n = Q_LED_ARG; state_n = ST_SEND; end
          default:   state_n = ST_IDLE;
        endcase
      end else if (ack_phase && bus.rx_data == BYTE_RESEND) begin
        resend_req = 1'b1;
      end else if (state == ST_WAIT_BAT && bus.rx_data == BYTE_BAT_OK) begin
        state_n = ST_IDLE;
      end else if (state == ST_WAIT_BAT && bus.rx_data == BYTE_BAT_FAIL) begin
        state_n = ST_FAULT;
      end else begin
        forward = 1'b1;
      end
    end

    // Resends reissue the strobe directly so retries are exactly TIMEOUT apart
    retry_due = resend_req || (expire && state_n == state);
    if (retry_due) begin
      if (exhausted) state_n = ST_FAULT;
      else begin
        bump    = 1'b1;
        send    = 1'b1;
        state_n = ST_WAIT_DONE;
      end
    end

    if (init) begin
      state_n   = ST_SEND;
      cmd_n     = Q_RST;
      send      = 1'b0;
      forward   = 1'b0;
      bump      = 1'b0;
      latch_led = 1'b0;
      ack       = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_SEND;
      cmd           <= Q_RST;
      bus.tx_req    <= 1'b0;
      bus.tx_data   <= BYTE_RESET;
      bus.key_valid <= 1'b0;
      bus.key_data  <= 8'h00;
    end else begin
      state         <= state_n;
      cmd           <= cmd_n;
      bus.tx_req    <= send;
      bus.key_valid <= forward;
      if (send)    bus.tx_data  <= queue_byte(cmd, led_arg);
      if (forward) bus.key_data <= bus.rx_data;
    end
  end

  assign timer_run   = (state == ST_WAIT_DONE) || (state == ST_WAIT_ACK) ||
                       (state == ST_WAIT_BAT);
  assign timer_clear = (state_n != state) || send;

  jtframe_ps2_timeout #(
    .TIMEOUT   (TIMEOUT),
    .MAX_RETRY (MAX_RETRY)
  ) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .clear     (timer_clear),
    .run       (timer_run),
    .bump      (bump),
    .ack       (ack),
    .expire    (expire),
    .exhausted (exhausted)
  );

`ifdef JTFRAME_PS2_LED_EN
  logic [2:0] led_sent;
  logic       pending;

  // An init that aborts an LED exchange re-arms the request for after BAT
  always_ff @(posedge clk) begin
    if (rst) begin
      led_sent <= 3'b000;
      pending  <= 1'b0;
    end else if (latch_led) begin
      led_sent <= led;
      pending  <= 1'b0;
    end else if ((init && cmd != Q_RST && state != ST_IDLE) || led != led_sent) begin
      pending  <= 1'b1;
    end
  end

  assign led_pending = pending;
  assign led_arg     = led_sent;
`else
  logic unused_led;
  assign unused_led  = ^{led, latch_led};
  assign led_pending = 1'b0;
  assign led_arg     = 3'b000;
`endif

  assign ready = (state == ST_IDLE);
  assign fault = (state == ST_FAULT);

endmodule

// File: doc/jtframe_ps2_cmd.md
JTFRAME_PS2_CMD -- requirements
Module: jtframe_ps2_cmd

Interface
REQ-001 SHALL have parameter TIMEOUT, default 24'd1_000_000: clk cycles to wait for a keyboard response before one retry.
REQ-002 SHALL have parameter MAX_RETRY, default 2: extra attempts per command byte before declaring a fault.
REQ-003 SHALL have port clk, input, 1: sole clock; every flop is on posedge clk.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port rx_data, input, 8: byte from the PS/2 receiver.
REQ-006 SHALL have port rx_valid, input, 1: one-cycle strobe qualifying rx_data.
REQ-007 SHALL have port tx_data, output, 8: byte for the PS/2 transmitter.
REQ-008 SHALL have port tx_req, output, 1: one-cycle send strobe.
REQ-009 SHALL have port tx_done, input, 1: one-cycle strobe when the transmitter finishes a byte.
REQ-010 SHALL have port led, input, 3: requested {caps,num,scroll} state.
REQ-011 SHALL have port init, input, 1: pulse that restarts the keyboard reset sequence.
REQ-012 SHALL have port key_data, output, 8: forwarded scan byte.
REQ-013 SHALL have port key_valid, output, 1: one-cycle strobe qualifying key_data.
REQ-014 SHALL have port ready, output, 1: high only in IDLE.
REQ-015 SHALL have port fault, output, 1: high only in FAULT.

Function
REQ-016 SHALL implement states SEND, WAIT_DONE, WAIT_ACK, WAIT_BAT, IDLE and FAULT, plus an internal command queue pointer (RST, LED_CMD, LED_ARG).
REQ-017 SHALL, in SEND, drive tx_data with the current byte and assert tx_req for exactly one cycle, then enter WAIT_DONE; tx_data SHALL hold its value until the next SEND.
REQ-018 SHALL, in WAIT_DONE, enter WAIT_ACK on tx_done.
REQ-019 SHALL act on rx_valid in WAIT_ACK as follows: 8'hFA is consumed; 8'hFE is consumed and resends the same byte, counting as a retry; any other byte is forwarded on key_data/key_valid.
REQ-020 SHALL take these steps after a consumed 8'hFA: after FF, go to WAIT_BAT; after ED, send {5'd0,led latched at ED time}; after the LED argument, go to IDLE.
REQ-021 SHALL, in WAIT_BAT, go to IDLE and consume the byte on rx 8'hAA; on rx 8'hFC go to FAULT; forward any other byte.
REQ-022 SHALL keep one timeout counter, cleared on entry to any WAIT state and counting each cycle while in one.
REQ-023 SHALL, when the counter reaches TIMEOUT-1, resend the current byte if the retry count is below MAX_RETRY, and otherwise go to FAULT.
REQ-024 SHALL clear the retry count when a byte is acknowledged.
REQ-025 SHALL forward every rx_valid byte in IDLE, with key_valid one cycle after rx_valid (latency 1).
REQ-026 SHALL set a pending flag on any change of led versus the last LED value sent, in any state.
REQ-027 SHALL, in IDLE with the pending flag set, clear the flag, latch led and send 8'hED.
REQ-028 SHALL, on an init pulse in any state, abort the current sequence and go to SEND with byte 8'hFF; init has priority over every other event.
REQ-029 SHALL leave FAULT only on init or rst.
REQ-030 SHALL, when rx_valid and tx_done arrive in the same cycle, process both events; neither is dropped.

Reset
REQ-031 SHALL, on rst, drive tx_req=0, tx_data=8'hFF, key_valid=0, key_data=0, ready=0 and fault=0, with retry and timeout counters at 0, the pending flag at 0 and last-sent LED at 3'b000.
REQ-032 SHALL enter SEND(FF) on the first cycle after rst deasserts.

Configuration
REQ-033 SHALL, with JTFRAME_PS2_LED_EN defined, include the LED synchronisation of REQ-020, REQ-026 and REQ-027.
REQ-034 SHALL, without JTFRAME_PS2_LED_EN, ignore led, never set the pending flag, never send 8'hED, and exclude the LED latch and pending flag logic from the build.

Structure
REQ-035 SHALL take the byte constants FF, ED, FA, FE, AA and FC and the state enumeration from shared package jtframe_ps2_pkg.
REQ-036 SHALL implement the timeout counter plus retry count as sub-module jtframe_ps2_timeout, with inputs clear and run and outputs expire and exhausted.

Verification
REQ-037 SHALL cover power-up: after rst, tx_done, rx FA and rx AA, tx_data=8'hFF and ready=1 the cycle after AA.
REQ-038 SHALL cover LED update: led 000->101 in IDLE, with two FA acks, sends 8'hED then 8'h05 and returns to IDLE.
REQ-039 SHALL cover resend: rx FE after ED sends ED again, and a following FA proceeds to 8'h05.
REQ-040 SHALL cover timeout with TIMEOUT=100 and MAX_RETRY=2 and no ack: exactly 3 FF sends, 100 cycles apart, then fault=1.
REQ-041 SHALL cover forwarding: rx 8'h1C in WAIT_ACK produces key_valid with key_data=8'h1C and the state does not change.
REQ-042 SHALL cover init in LED mid-sequence: the next tx_data=8'hFF, and the pending led change is serviced after AA.
